// File: rtl/jt12_eg_sched_if.sv
// Bus between the envelope scheduler and the combinational envelope datapath.
// The master side presents per-slot context; the slave side returns the next context.
interface jt12_eg_sched_if;
  // scheduler -> datapath
  logic       keyon_now;
  logic       keyoff_now;
  logic [2:0] state_in;
  logic [9:0] eg_in;
  logic       ssg_inv_in;
  logic       cnt_in;
  // datapath -> scheduler
  logic [2:0] state_next;
  logic [9:0] eg_next;
  logic       ssg_inv_out;
  logic       cnt_lsb;
  logic       pg_rst;
  logic [9:0] final_eg;

  modport master (
    output keyon_now, keyoff_now, state_in, eg_in, ssg_inv_in, cnt_in,
    input  state_next, eg_next, ssg_inv_out, cnt_lsb, pg_rst, final_eg
  );

  modport slave (
    input  keyon_now, keyoff_now, state_in, eg_in, ssg_inv_in, cnt_in,
    output state_next, eg_next, ssg_inv_out, cnt_lsb, pg_rst, final_eg
  );
endinterface

// File: rtl/jt12_eg_sched.sv
// Envelope-generator slot sequencer: per-slot context store, write-back of the
// combinational results, slot-tagged registered envelope output and eg_cnt.
module jt12_eg_sched #(
  parameter int SLOTS  = 24,
  parameter int EG_DIV = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        kon,
  jt12_eg_sched_if.master bus,
  output logic [14:0] eg_cnt,
  output logic [4:0]  slot,
  output logic        zero,
  output logic [9:0]  eg_out,
  output logic [4:0]  eg_slot,
  output logic        pg_rst_out
);

  typedef enum logic [2:0] {
    PH_RELEASE = 3'b000,
    PH_ATTACK  = 3'b001,
    PH_DECAY   = 3'b010,
    PH_HOLD    = 3'b100
  } phase_t;

  localparam int          DIV_W     = (EG_DIV > 1) ? $clog2(EG_DIV) : 1;
  localparam logic [4:0]  LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(EG_DIV - 1);

  phase_t     state_q   [SLOTS];
  phase_t     state_d   [SLOTS];
  logic [9:0] eg_q      [SLOTS];
  logic [9:0] eg_d      [SLOTS];
  logic       inv_q     [SLOTS];
  logic       inv_d     [SLOTS];
  logic       kon_last_q[SLOTS];
  logic       kon_last_d[SLOTS];
  logic       cnt_q     [SLOTS];
  logic       cnt_d     [SLOTS];

  logic [4:0]       slot_q,       slot_d;
  logic [DIV_W-1:0] div_q,        div_d;
  logic [14:0]      eg_cnt_q,     eg_cnt_d;
  logic [9:0]       eg_out_q,     eg_out_d;
  logic [4:0]       eg_slot_q,    eg_slot_d;
  logic             pg_rst_out_q, pg_rst_out_d;

  // Datapath-facing reads of the current slot's context.
  always_comb begin
    bus.state_in   = state_q[slot_q];
    bus.eg_in      = eg_q[slot_q];
    bus.ssg_inv_in = inv_q[slot_q];
    bus.cnt_in     = cnt_q[slot_q];
    bus.keyon_now  =  kon & ~kon_last_q[slot_q];
    bus.keyoff_now = ~kon &  kon_last_q[slot_q];
  end

  always_comb begin
    state_d      = state_q;
    eg_d         = eg_q;
    inv_d        = inv_q;
    kon_last_d   = kon_last_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    div_d        = div_q;
    eg_cnt_d     = eg_cnt_q;
    eg_out_d     = eg_out_q;
    eg_slot_d    = eg_slot_q;
    pg_rst_out_d = pg_rst_out_q;

    if (clk_en) begin
      state_d[slot_q]    = phase_t'(bus.state_next);
      eg_d[slot_q]       = bus.eg_next;
      inv_d[slot_q]      = bus.ssg_inv_out;
      kon_last_d[slot_q] = kon;
      cnt_d[slot_q]      = bus.cnt_lsb;

      eg_out_d     = bus.final_eg;
      eg_slot_d    = slot_q;
      pg_rst_out_d = bus.pg_rst;

      // The last slot closes a sample; eg_cnt advances once per EG_DIV samples.
      if (slot_q == LAST_SLOT) begin
        slot_d = '0;
        if (div_q == LAST_DIV) begin
          div_d    = '0;
          eg_cnt_d = eg_cnt_q + 15'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end else begin
        slot_d = slot_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        state_q[i]    <= PH_RELEASE;
        eg_q[i]       <= '1;
        inv_q[i]      <= 1'b0;
        kon_last_q[i] <= 1'b0;
        cnt_q[i]      <= 1'b0;
      end
      slot_q       <= '0;
      div_q        <= '0;
      eg_cnt_q     <= '0;
      eg_out_q     <= '1;
      eg_slot_q    <= '0;
      pg_rst_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      eg_q         <= eg_d;
      inv_q        <= inv_d;
      kon_last_q   <= kon_last_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      div_q        <= div_d;
      eg_cnt_q     <= eg_cnt_d;
      eg_out_q     <= eg_out_d;
      eg_slot_q    <= eg_slot_d;
      pg_rst_out_q <= pg_rst_out_d;
    end
  end

  assign slot       = slot_q;
  assign zero       = (slot_q == 5'd0);
  assign eg_cnt     = eg_cnt_q;
  assign eg_out     = eg_out_q;
  assign eg_slot    = eg_slot_q;
  assign pg_rst_out = pg_rst_out_q;

endmodule

// File: doc/jt12_eg_sched.md
Name: jt12_eg_sched

Overview:
- Time-multiplexed sequencer for the envelope-generator combinational datapath (jt12_eg_comb).
- Walks the 24 operator slots in order and keeps per-slot envelope context: phase state, attenuation, SSG inversion, key-on history and counter carry bit.
- For the current slot it presents that context to the combinational stages, writes the results back, and emits a registered, slot-tagged envelope to the operator pipeline.
- Also generates the global envelope counter eg_cnt.

Parameters:
SLOTS, 24, number of operator slots in the rotation (counter wraps at SLOTS-1)
EG_DIV, 3, samples per eg_cnt increment

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  slot-advance enable; when 0, no state changes
kon  in  1  key-on level for the current slot, from the register file
keyon_now  out  1  comb: kon & ~kon_last[slot]
keyoff_now  out  1  comb: ~kon & kon_last[slot]
state_in  out  3  comb: stored phase of the current slot
eg_in  out  10  comb: stored attenuation of the current slot
ssg_inv_in  out  1  comb: stored SSG inversion bit
cnt_in  out  1  comb: stored counter carry bit of the current slot
eg_cnt  out  15  global envelope counter
state_next  in  3  comb: next phase
eg_next  in  10  comb: next pure attenuation (pure_eg_out)
ssg_inv_out  in  1  comb: next inversion bit
cnt_lsb  in  1  comb: counter carry bit to store
pg_rst  in  1  comb: phase-generator reset request
final_eg  in  10  comb stage IV attenuation for the current slot
slot  out  5  current slot index 0..SLOTS-1
zero  out  1  high while slot==0 (sample boundary)
eg_out  out  10  registered final_eg of the previous slot
eg_slot  out  5  slot tag for eg_out
pg_rst_out  out  1  registered pg_rst, same tag as eg_out

Behaviour:
- Phase encoding (one-hot): ATTACK=3'b001, DECAY=3'b010, HOLD=3'b100, RELEASE=3'b000.
- Context store: flop arrays, 24 x {state[2:0], eg[9:0], ssg_inv, kon_last, cnt}.
- Reset (synchronous, any cycle, overrides clk_en):
  - slot=0, div=0, eg_cnt=0.
  - Every slot set to state=RELEASE, eg=10'h3FF, ssg_inv=0, kon_last=0, cnt=0.
  - eg_out=10'h3FF, eg_slot=0, pg_rst_out=0.
- Comb-facing outputs (keyon_now, keyoff_now, state_in, eg_in, ssg_inv_in, cnt_in) are combinational reads of entry [slot] plus kon.
- On each clk_en edge:
  - Entry [slot] takes {state_next, eg_next, ssg_inv_out, kon, cnt_lsb}.
  - eg_out<=final_eg, eg_slot<=slot, pg_rst_out<=pg_rst.
  - slot increments, wrapping SLOTS-1 -> 0.
  - Latency is one clk_en edge from slot presentation to eg_out.
- Divider and counter:
  - div counts samples 0..EG_DIV-1 and advances on the edge where slot==SLOTS-1.
  - When div==EG_DIV-1 at that edge: div->0 and eg_cnt increments, wrapping 15'h7FFF -> 0.
- clk_en=0: every register holds its value; comb-facing outputs stay stable.
- kon held high: key-on is edge-detected, so keyon_now is high once, on the first visit only. kon falling gives one keyoff_now.
- kon toggling only while clk_en=0 produces no event.
- Only entry [slot] is written per edge; other slots are untouched.

Test Plan:
- Reset, then 24 clk_en pulses: slot runs 0..23 and returns to 0; zero high only at slot 0; every eg_in reads 3FF and every state_in reads 000.
- 72 clk_en pulses (3 samples): eg_cnt goes 0 -> 1 exactly on the edge leaving slot 23 of the third sample; 7FFF wraps to 0.
- kon=1 on slot 5 for two rotations: keyon_now=1 only on the first visit; with comb stub state_next=001, eg_next=0, slot 5 reads state_in=001, eg_in=0 on the next visit; kon=0 then gives one keyoff_now.
- Stub final_eg=slot*10, pulse clk_en: eg_out equals previous slot*10 with matching eg_slot; pg_rst=1 on slot 7 gives pg_rst_out=1 with eg_slot=7.
- clk_en low 10 cycles mid-rotation at slot 12: slot, eg_cnt and all outputs unchanged.
- Assert rst at slot 17 with non-default contexts: the next cycle shows slot=0, eg_cnt=0, all contexts at reset values.
